// File: rtl/modn_counter.sv
// ----------------------------------------------------------------------------
// modn_counter
//
// Parametrised modulo-N up/down counter. It counts 0..MODULUS-1 in either
// direction and has a synchronous clear, a parallel load with range checking,
// a registered wrap pulse, and a combinational terminal-count output. The
// terminal-count output lets multi-digit counters be chained without ripple
// delay through the registers. Typical uses are BCD digits, prescalers and
// timebase dividers.
//
// Parameters
//   WIDTH     counter width in bits
//   MODULUS   count range 0..MODULUS-1, where 2 <= MODULUS <= 2**WIDTH
//
// Ports
//   clk       in   1      rising-edge clock
//   rst       in   1      asynchronous active-low reset
//   en        in   1      count enable (carry-in when cascaded)
//   dir       in   1      0 = count up, 1 = count down
//   clr       in   1      synchronous clear to 0 (highest priority)
//   load      in   1      synchronous parallel load
//   load_val  in   WIDTH  value for load
//   cntr      out  WIDTH  current count, registered
//   cy        out  1      registered one-cycle pulse following a wrap edge
//   tc        out  1      combinational terminal count (cascade enable)
//   load_err  out  1      registered one-cycle pulse: out-of-range load
// ----------------------------------------------------------------------------
module modn_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cntr,
    output logic             cy,
    output logic             tc,
    output logic             load_err
);

    // Reject a modulus the counter cannot represent. The check runs at
    // elaboration, so an illegal build never produces a netlist.
    generate
        if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
            $error("modn_counter: MODULUS=%0d outside 2..2**WIDTH (WIDTH=%0d)",
                   MODULUS, WIDTH);
        end
    endgenerate

    // Top count value at WIDTH bits. The modulus is held at WIDTH+1 bits so
    // the load range check stays correct when MODULUS == 2**WIDTH, because
    // every load_val is then legal.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] cntr_q, cntr_d;
    logic             cy_q, cy_d;
    logic             load_err_q, load_err_d;

    logic at_top;
    logic at_zero;
    logic load_ok;

    assign at_top  = (cntr_q == MAX_VAL);
    assign at_zero = (cntr_q == '0);
    assign load_ok = ({1'b0, load_val} < MOD_EXT);

    // Next-state logic. The priority order is clr > load > en > hold.
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        cntr_d     = cntr_q;
        cy_d       = 1'b0;
        load_err_d = 1'b0;

        if (clr) begin
            cntr_d = '0;
        end else if (load) begin
            // A load never counts as a wrap. An out-of-range value is
            // replaced by 0 so the counter cannot leave its legal range.
            if (load_ok) begin
                cntr_d = load_val;
            end else begin
                cntr_d     = '0;
                load_err_d = 1'b1;
            end
        end else if (en) begin
            if (dir) begin
                if (at_zero) begin
                    cntr_d = MAX_VAL;
                    cy_d   = 1'b1;
                end else begin
                    cntr_d = cntr_q - WIDTH'(1);
                end
            end else begin
                if (at_top) begin
                    cntr_d = '0;
                    cy_d   = 1'b1;
                end else begin
                    cntr_d = cntr_q + WIDTH'(1);
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments, so every flop
    // samples its pre-edge value regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cntr_q     <= '0;
            cy_q       <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            cntr_q     <= cntr_d;
            cy_q       <= cy_d;
            load_err_q <= load_err_d;
        end
    end

    // tc has zero latency. It goes high in the same cycle the next enabled
    // edge will wrap, so the next digit's enable sees it before that edge.
    assign tc       = en & ~clr & ~load & (dir ? at_zero : at_top);

    assign cntr     = cntr_q;
    assign cy       = cy_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_modn_counter.sv
// ----------------------------------------------------------------------------
// tb_modn_counter
//
// Testbench for modn_counter. It exercises a mod-10 digit under directed and
// random stimulus, a two-digit cascade, and an octal (WIDTH=3, MODULUS=8)
// instance. Expected values come from arithmetic modulo the counter's range.
// ----------------------------------------------------------------------------
module tb_modn_counter;

    localparam int M  = 10;
    localparam int MO = 8;

    logic clk;
    logic rst;

    // Inputs and outputs of the main mod-10 instance.
    logic       en, dir, clr, load;
    logic [3:0] load_val;
    logic [3:0] cntr;
    logic       cy, tc, load_err;

    // Two-digit cascade. Digit 1 is enabled by digit 0's tc.
    logic       c_en, c_zero;
    logic [3:0] c_lv;
    logic [3:0] c_cntr0, c_cntr1;
    logic       c_cy0, c_cy1, c_tc0, c_tc1, c_le0, c_le1;

    // Octal instance.
    logic       o_en, o_dir;
    logic [2:0] o_lv;
    logic [2:0] o_cntr;
    logic       o_cy, o_tc, o_le;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state of the main instance.
    int m_cnt, m_cy, m_le;

    modn_counter #(.WIDTH(4), .MODULUS(M)) dut (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .clr(clr), .load(load),
        .load_val(load_val), .cntr(cntr), .cy(cy), .tc(tc), .load_err(load_err)
    );

    modn_counter #(.WIDTH(4), .MODULUS(M)) u_d0 (
        .clk(clk), .rst(rst), .en(c_en), .dir(c_zero), .clr(c_zero),
        .load(c_zero), .load_val(c_lv), .cntr(c_cntr0), .cy(c_cy0),
        .tc(c_tc0), .load_err(c_le0)
    );

    modn_counter #(.WIDTH(4), .MODULUS(M)) u_d1 (
        .clk(clk), .rst(rst), .en(c_tc0), .dir(c_zero), .clr(c_zero),
        .load(c_zero), .load_val(c_lv), .cntr(c_cntr1), .cy(c_cy1),
        .tc(c_tc1), .load_err(c_le1)
    );

    modn_counter #(.WIDTH(3), .MODULUS(MO)) u_oct (
        .clk(clk), .rst(rst), .en(o_en), .dir(o_dir), .clr(c_zero),
        .load(c_zero), .load_val(o_lv), .cntr(o_cntr), .cy(o_cy),
        .tc(o_tc), .load_err(o_le)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Runs one clock cycle on the main instance. tc is checked against the
    // reference before the edge, then the registered outputs after it.
    task automatic cycle(input logic i_en, input logic i_dir, input logic i_clr,
                         input logic i_load, input int i_lv, input string tag);
        int exp_tc;
        en       = i_en;
        dir      = i_dir;
        clr      = i_clr;
        load     = i_load;
        load_val = 4'(i_lv);
        #1;
        exp_tc = (i_en && !i_clr && !i_load &&
                  (i_dir ? (m_cnt == 0) : (m_cnt == M - 1))) ? 1 : 0;
        check({tag, ".tc"}, 32'(tc), 32'(exp_tc));
        @(posedge clk);
        if (i_clr) begin
            m_cnt = 0; m_cy = 0; m_le = 0;
        end else if (i_load) begin
            m_cy = 0;
            if (i_lv < M) begin m_cnt = i_lv; m_le = 0; end
            else          begin m_cnt = 0;    m_le = 1; end
        end else if (i_en) begin
            m_le = 0;
            if (i_dir) begin
                m_cy  = (m_cnt == 0) ? 1 : 0;
                m_cnt = (m_cnt + M - 1) % M;
            end else begin
                m_cy  = (m_cnt == M - 1) ? 1 : 0;
                m_cnt = (m_cnt + 1) % M;
            end
        end else begin
            m_cy = 0; m_le = 0;
        end
        #1;
        check({tag, ".cntr"},     32'(cntr),     32'(m_cnt));
        check({tag, ".cy"},       32'(cy),       32'(m_cy));
        check({tag, ".load_err"}, 32'(load_err), 32'(m_le));
    endtask

    initial begin
        int v;
        int pulses;
        int oc;
        int exp_ocy;

        rst = 1'b1;
        en = 0; dir = 0; clr = 0; load = 0; load_val = '0;
        c_en = 0; c_zero = 0; c_lv = '0;
        o_en = 0; o_dir = 0; o_lv = '0;
        m_cnt = 0; m_cy = 0; m_le = 0;

        // Reset state.
        #2 rst = 1'b0;
        #1;
        check("reset.cntr",     32'(cntr),     0);
        check("reset.cy",       32'(cy),       0);
        check("reset.load_err", 32'(load_err), 0);
        check("reset.oct",      32'(o_cntr),   0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Count up through a wrap.
        for (int i = 0; i < 12; i++) cycle(1, 0, 0, 0, 0, "up");

        // Count down from 0 through a wrap.
        cycle(0, 0, 1, 0, 0, "clr_pre_down");
        for (int i = 0; i < 12; i++) cycle(1, 1, 0, 0, 0, "down");

        // Load a legal value, then an out-of-range one, then idle.
        cycle(0, 0, 0, 1, 7,  "load7");
        cycle(0, 0, 0, 1, 12, "load12");
        cycle(0, 0, 0, 0, 0,  "load_idle");
        cycle(0, 0, 0, 1, 9,  "load9");
        cycle(0, 0, 0, 1, 10, "load10");
        check("load10.direct_err", 32'(load_err), 1);

        // clr wins over load and en at cntr == 9.
        cycle(0, 0, 0, 1, 9, "load9b");
        cycle(1, 0, 1, 1, 5, "clr_prio");
        check("clr_prio.direct_cntr", 32'(cntr), 0);

        // Load wins over en, and no cy is raised even at the wrap point.
        cycle(0, 0, 0, 1, 9, "load9c");
        cycle(1, 0, 0, 1, 3, "load_prio");

        // Random mix of all controls.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 9) == 0),
                  int'($urandom_range(0, 15)), "rand");
        end
        cycle(0, 0, 0, 0, 0, "rand_idle");

        // Two-digit cascade: 100 enabled cycles wrap 99 -> 00 once.
        v = 0;
        pulses = 0;
        c_en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            v = (v + 1) % 100;
            #1;
            check("casc.d0", 32'(c_cntr0), 32'(v % 10));
            check("casc.d1", 32'(c_cntr1), 32'(v / 10));
            check("casc.cy1", 32'(c_cy1), (v == 0) ? 1 : 0);
            if (c_cy1 === 1'b1) pulses++;
        end
        c_en = 1'b0;
        check("casc.cy1_pulses", 32'(pulses), 1);

        // Octal instance counts 0..7 and wraps.
        oc = 0;
        o_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("oct.tc", 32'(o_tc), (oc == MO - 1) ? 1 : 0);
            @(posedge clk);
            exp_ocy = (oc == MO - 1) ? 1 : 0;
            oc = (oc + 1) % MO;
            #1;
            check("oct.cntr", 32'(o_cntr), 32'(oc));
            check("oct.cy",   32'(o_cy),   32'(exp_ocy));
        end
        o_en = 1'b0;

        // Asserting reset between edges clears outputs and a pending cy.
        cycle(0, 0, 0, 1, 9, "pre_rst_load");
        cycle(1, 0, 0, 0, 0, "pre_rst_wrap");
        check("pre_rst.cy_pending", 32'(cy), 1);
        rst = 1'b0;
        #1;
        check("midrst.cntr", 32'(cntr),   0);
        check("midrst.cy",   32'(cy),     0);
        check("midrst.oct",  32'(o_cntr), 0);
        check("midrst.d0",   32'(c_cntr0), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        m_cnt = 0; m_cy = 0; m_le = 0;
        cycle(1, 0, 0, 0, 0, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
